// File: rtl/uart_pkg.sv
// Shared types and constants for the UART receive path: FSM state encoding,
// parity-mode encoding and the legal data-frame length range.
package uart_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4
  } rx_state_t;

  localparam logic PARITY_EVEN = 1'b0;
  localparam logic PARITY_ODD  = 1'b1;

  localparam int FRAME_LEN_MIN = 5;
  localparam int FRAME_LEN_MAX = 9;

  // Bound a requested data-bit count to [FRAME_LEN_MIN, max_bits].
  function automatic logic [3:0] clamp_frame_len(input logic [3:0] len,
                                                 input logic [3:0] max_bits);
    logic [3:0] res;
    res = len;
    if (len < 4'(FRAME_LEN_MIN)) begin
      res = 4'(FRAME_LEN_MIN);
    end else if (len > max_bits) begin
      res = max_bits;
    end
    return res;
  endfunction

endpackage

// File: rtl/uart_rx_sampler.sv
// Line synchroniser, oversample tick counter and mid-bit sampler.
// Define UART_RX_MAJORITY_EN for a 2-of-3 vote around the bit centre.
module uart_rx_sampler #(
  parameter int OVERSAMPLE = 16
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_rx,
  input  logic i_clr,
  output logic o_rx_sync,
  output logic o_bit,
  output logic o_mid
);

  localparam int TICK_W = $clog2(OVERSAMPLE);
`ifdef UART_RX_MAJORITY_EN
  // Strobe one tick late so the third vote sample is already in hand.
  localparam int MID_TICK = OVERSAMPLE / 2;
`else
  localparam int MID_TICK = OVERSAMPLE / 2 - 1;
`endif

  logic [1:0]        r_sync;
  logic [TICK_W-1:0] r_tick;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_sync <= 2'b11;
      r_tick <= '0;
    end else begin
      r_sync <= {r_sync[0], i_rx};
      if (i_clr || (r_tick == TICK_W'(OVERSAMPLE - 1))) begin
        r_tick <= '0;
      end else begin
        r_tick <= r_tick + TICK_W'(1);
      end
    end
  end

  assign o_rx_sync = r_sync[1];
  assign o_mid     = (r_tick == TICK_W'(MID_TICK));

`ifdef UART_RX_MAJORITY_EN
  logic [1:0] r_hist;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_hist <= 2'b11;
    end else begin
      r_hist <= {r_hist[0], r_sync[1]};
    end
  end

  assign o_bit = (r_hist[1] & r_hist[0]) | (r_hist[1] & r_sync[1]) | (r_hist[0] & r_sync[1]);
`else
  assign o_bit = r_sync[1];
`endif

endmodule

// File: rtl/uart_rx_engine.sv
// Oversampled UART receiver: frame FSM plus a one-word holding register with
// overrun detection. Build with UART_RX_MAJORITY_EN for majority-vote sampling.
module uart_rx_engine
  import uart_pkg::*;
#(
  parameter int OVERSAMPLE    = 16,
  parameter int MAX_DATA_BITS = 9
) (
  input  logic                     clk_16bd,
  input  logic                     rst,
  input  logic                     rx,
  input  logic                     parity_en,
  input  logic                     parity_odd,
  input  logic                     stop_bits,
  input  logic [3:0]               frame_length,
  input  logic                     rdy,
  output logic [MAX_DATA_BITS-1:0] data,
  output logic                     data_valid,
  output logic                     parity_err,
  output logic                     framing_err,
  output logic                     overrun,
  output logic                     busy
);

  localparam logic [3:0] LEN_CAP = (MAX_DATA_BITS > FRAME_LEN_MAX) ?
                                   4'(FRAME_LEN_MAX) : 4'(MAX_DATA_BITS);

  rx_state_t                r_state;
  logic [3:0]               r_bit_cnt;
  logic                     r_stop_cnt;
  logic [3:0]               r_len;
  logic                     r_par_en;
  logic                     r_par_odd;
  logic                     r_stop2;
  logic [MAX_DATA_BITS-1:0] r_shift;
  logic                     r_par_acc;
  logic                     r_par_err;
  logic                     r_frm_err;
  logic                     r_busy;

  logic [MAX_DATA_BITS-1:0] r_data;
  logic                     r_valid;
  logic                     r_par_out;
  logic                     r_frm_out;
  logic                     r_overrun;

  logic                     w_rx_sync;
  logic                     w_bit;
  logic                     w_mid;
  logic                     w_clr;
  logic                     w_last_data;
  logic                     w_last_stop;
  logic                     w_complete;
  logic                     w_frm_err_final;
  logic [MAX_DATA_BITS-1:0] w_bit_sel;

  uart_rx_sampler #(
    .OVERSAMPLE(OVERSAMPLE)
  ) u_sampler (
    .i_clk    (clk_16bd),
    .i_rst    (rst),
    .i_rx     (rx),
    .i_clr    (w_clr),
    .o_rx_sync(w_rx_sync),
    .o_bit    (w_bit),
    .o_mid    (w_mid)
  );

  // One-hot write enable selects where the next LSB-first data bit lands.
  for (genvar gi = 0; gi < MAX_DATA_BITS; gi++) begin : g_bit_sel
    assign w_bit_sel[gi] = (r_bit_cnt == 4'(gi));
  end

  assign w_clr           = (r_state == ST_IDLE) && !w_rx_sync;
  assign w_last_data     = (r_bit_cnt == (r_len - 4'd1));
  assign w_last_stop     = (r_stop_cnt == r_stop2);
  assign w_complete      = (r_state == ST_STOP) && w_mid && w_last_stop;
  assign w_frm_err_final = r_frm_err | !w_bit;

  always_ff @(posedge clk_16bd) begin
    if (rst) begin
      r_state    <= ST_IDLE;
      r_bit_cnt  <= '0;
      r_stop_cnt <= 1'b0;
      r_len      <= '0;
      r_par_en   <= 1'b0;
      r_par_odd  <= PARITY_EVEN;
      r_stop2    <= 1'b0;
      r_shift    <= '0;
      r_par_acc  <= 1'b0;
      r_par_err  <= 1'b0;
      r_frm_err  <= 1'b0;
      r_busy     <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (!w_rx_sync) begin
            r_state    <= ST_START;
            r_busy     <= 1'b1;
            r_len      <= clamp_frame_len(frame_length, LEN_CAP);
            r_par_en   <= parity_en;
            r_par_odd  <= parity_odd;
            r_stop2    <= stop_bits;
            r_bit_cnt  <= '0;
            r_stop_cnt <= 1'b0;
            r_shift    <= '0;
            r_par_acc  <= 1'b0;
            r_par_err  <= 1'b0;
            r_frm_err  <= 1'b0;
          end
        end
        ST_START: begin
          if (w_mid) begin
            if (w_bit) begin
              r_state <= ST_IDLE;
              r_busy  <= 1'b0;
            end else begin
              r_state <= ST_DATA;
            end
          end
        end
        ST_DATA: begin
          if (w_mid) begin
            r_shift   <= (r_shift & ~w_bit_sel) | ({MAX_DATA_BITS{w_bit}} & w_bit_sel);
            r_par_acc <= r_par_acc ^ w_bit;
            r_bit_cnt <= r_bit_cnt + 4'd1;
            if (w_last_data) begin
              r_state <= r_par_en ? ST_PARITY : ST_STOP;
            end
          end
        end
        ST_PARITY: begin
          if (w_mid) begin
            r_par_err <= r_par_acc ^ w_bit ^ (r_par_odd == PARITY_ODD);
            r_state   <= ST_STOP;
          end
        end
        ST_STOP: begin
          if (w_mid) begin
            r_frm_err <= w_frm_err_final;
            // Leaving at mid-bit lets a start edge in the tail of the stop bit be seen.
            if (w_last_stop) begin
              r_state <= ST_IDLE;
              r_busy  <= 1'b0;
            end else begin
              r_stop_cnt <= 1'b1;
            end
          end
        end
        default: begin
          r_state <= ST_IDLE;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  // Holding register: a completed frame only replaces the word if it is free
  // or being consumed this very cycle; otherwise the new frame is dropped.
  always_ff @(posedge clk_16bd) begin
    if (rst) begin
      r_data    <= '0;
      r_valid   <= 1'b0;
      r_par_out <= 1'b0;
      r_frm_out <= 1'b0;
      r_overrun <= 1'b0;
    end else begin
      r_overrun <= 1'b0;
      if (w_complete) begin
        if (!r_valid || rdy) begin
          r_data    <= r_shift;
          r_valid   <= 1'b1;
          r_par_out <= r_par_err;
          r_frm_out <= w_frm_err_final;
        end else begin
          r_overrun <= 1'b1;
        end
      end else if (r_valid && rdy) begin
        r_valid <= 1'b0;
      end
    end
  end

  assign data        = r_data;
  assign data_valid  = r_valid;
  assign parity_err  = r_par_out;
  assign framing_err = r_frm_out;
  assign overrun     = r_overrun;
  assign busy        = r_busy;

endmodule

// File: tb/tb_uart_rx_engine.sv
// Self-checking bench for uart_rx_engine: serial frames are driven bit by bit,
// expected words are queued at send time and compared when the DUT hands them over.
module tb_uart_rx_engine;

  localparam int OS = 16;

  logic       clk = 1'b0;
  logic       rst;
  logic       rx;
  logic       parity_en;
  logic       parity_odd;
  logic       stop_bits;
  logic [3:0] frame_length;
  logic       rdy;
  logic [8:0] data;
  logic       data_valid;
  logic       parity_err;
  logic       framing_err;
  logic       overrun;
  logic       busy;

  typedef struct packed {
    logic [8:0] d;
    logic       pe;
    logic       fe;
  } exp_t;

  exp_t sb_q[$];
  exp_t mon_e;
  bit   sb_on = 1'b0;
  int   n_checks = 0;
  int   n_fail = 0;
  int   n_ovr = 0;

  always #5 clk = ~clk;

  uart_rx_engine #(
    .OVERSAMPLE   (OS),
    .MAX_DATA_BITS(9)
  ) dut (
    .clk_16bd    (clk),
    .rst         (rst),
    .rx          (rx),
    .parity_en   (parity_en),
    .parity_odd  (parity_odd),
    .stop_bits   (stop_bits),
    .frame_length(frame_length),
    .rdy         (rdy),
    .data        (data),
    .data_valid  (data_valid),
    .parity_err  (parity_err),
    .framing_err (framing_err),
    .overrun     (overrun),
    .busy        (busy)
  );

  // Scoreboard consumer: every accepted word is matched against the queue head.
  always @(negedge clk) begin
    if (overrun === 1'b1) n_ovr++;
    if (sb_on && data_valid === 1'b1 && rdy === 1'b1) begin
      n_checks++;
      if (sb_q.size() == 0) begin
        n_fail++;
        $display("FAIL sb_unexpected: got data=%h pe=%b fe=%b, required no word", data, parity_err, framing_err);
      end else begin
        mon_e = sb_q.pop_front();
        $display("RX word data=%h pe=%b fe=%b (expected %h %b %b)", data, parity_err, framing_err, mon_e.d, mon_e.pe, mon_e.fe);
        if (data !== mon_e.d) begin
          n_fail++;
          $display("FAIL sb_data: got %h, required %h", data, mon_e.d);
        end
        n_checks++;
        if (parity_err !== mon_e.pe) begin
          n_fail++;
          $display("FAIL sb_parity_err: got %b, required %b", parity_err, mon_e.pe);
        end
        n_checks++;
        if (framing_err !== mon_e.fe) begin
          n_fail++;
          $display("FAIL sb_framing_err: got %b, required %b", framing_err, mon_e.fe);
        end
      end
    end
  end

  // Drive one frame; abort_at >= 0 asserts rst instead of driving that bit.
  task automatic send_frame(input logic [8:0] d, input int nbits, input logic [3:0] len_cfg,
                            input logic pen, input logic podd, input logic stop2,
                            input logic bad_par, input logic bad_stop, input int abort_at);
    logic bits [16];
    int   nb;
    logic p;
    nb = 0;
    p  = 1'b0;
    bits[nb] = 1'b0;
    nb++;
    for (int i = 0; i < nbits; i++) begin
      bits[nb] = d[i];
      p = p ^ d[i];
      nb++;
    end
    if (pen) begin
      bits[nb] = p ^ podd ^ bad_par;
      nb++;
    end
    if (stop2) begin
      bits[nb] = 1'b1;
      nb++;
    end
    bits[nb] = ~bad_stop;
    nb++;
    parity_en    = pen;
    parity_odd   = podd;
    stop_bits    = stop2;
    frame_length = len_cfg;
    @(posedge clk);
    #1;
    for (int k = 0; k < nb; k++) begin
      if (k == abort_at) begin
        rst = 1'b1;
        rx  = 1'b1;
        @(posedge clk);
        #1;
        return;
      end
      rx = bits[k];
      repeat (OS) @(posedge clk);
      #1;
    end
    rx = 1'b1;
  endtask

  task automatic test_reset;
    rst = 1'b1;
    rx = 1'b1;
    rdy = 1'b1;
    parity_en = 1'b0;
    parity_odd = 1'b0;
    stop_bits = 1'b0;
    frame_length = 4'd8;
    repeat (3) @(posedge clk);
    #1;
    n_checks++; if (data !== 9'h000) begin n_fail++; $display("FAIL reset_data: got %h, required 000", data); end
    n_checks++; if (data_valid !== 1'b0) begin n_fail++; $display("FAIL reset_data_valid: got %b, required 0", data_valid); end
    n_checks++; if (parity_err !== 1'b0) begin n_fail++; $display("FAIL reset_parity_err: got %b, required 0", parity_err); end
    n_checks++; if (framing_err !== 1'b0) begin n_fail++; $display("FAIL reset_framing_err: got %b, required 0", framing_err); end
    n_checks++; if (overrun !== 1'b0) begin n_fail++; $display("FAIL reset_overrun: got %b, required 0", overrun); end
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b, required 0", busy); end
    rst = 1'b0;
    repeat (4) @(posedge clk);
  endtask

  task automatic test_8n1;
    int lat;
    lat = 0;
    sb_on = 1'b1;
    sb_q.push_back('{9'h055, 1'b0, 1'b0});
    fork
      send_frame(9'h055, 8, 4'd8, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, -1);
      begin
        @(negedge rx);
        while (lat < 300) begin
          @(posedge clk);
          lat++;
          #2;
          if (data_valid === 1'b1) break;
        end
      end
    join
    n_checks++;
    if (lat > 155) begin
      n_fail++;
      $display("FAIL latency_8n1: got %0d cycles, required <= 155", lat);
    end
    for (int i = 0; i < 400 && sb_q.size() != 0; i++) @(posedge clk);
    n_checks++; if (sb_q.size() != 0) begin n_fail++; $display("FAIL drain_8n1: got %0d pending, required 0", sb_q.size()); end
  endtask

  task automatic test_parity;
    sb_q.push_back('{9'h1A5, 1'b1, 1'b0});
    send_frame(9'h1A5, 9, 4'd9, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, -1);
    sb_q.push_back('{9'h05A, 1'b0, 1'b0});
    send_frame(9'h05A, 7, 4'd7, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, -1);
    sb_q.push_back('{9'h0F0, 1'b1, 1'b0});
    send_frame(9'h0F0, 8, 4'd8, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, -1);
    for (int i = 0; i < 400 && sb_q.size() != 0; i++) @(posedge clk);
    n_checks++; if (sb_q.size() != 0) begin n_fail++; $display("FAIL drain_parity: got %0d pending, required 0", sb_q.size()); end
  endtask

  task automatic test_framing;
    sb_q.push_back('{9'h0C3, 1'b0, 1'b1});
    send_frame(9'h0C3, 8, 4'd8, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, -1);
    repeat (3 * OS) @(posedge clk);
    sb_q.push_back('{9'h03C, 1'b0, 1'b0});
    send_frame(9'h03C, 8, 4'd8, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, -1);
    for (int i = 0; i < 400 && sb_q.size() != 0; i++) @(posedge clk);
    n_checks++; if (sb_q.size() != 0) begin n_fail++; $display("FAIL drain_framing: got %0d pending, required 0", sb_q.size()); end
  endtask

  task automatic test_false_start;
    bit saw_busy;
    saw_busy = 1'b0;
    frame_length = 4'd8;
    @(posedge clk);
    #1;
    rx = 1'b0;
    for (int i = 0; i < 12; i++) begin
      if (i == 4) rx = 1'b1;
      @(posedge clk);
      #1;
      if (busy === 1'b1) saw_busy = 1'b1;
    end
    repeat (2 * OS) @(posedge clk);
    #1;
    n_checks++; if (saw_busy !== 1'b1) begin n_fail++; $display("FAIL false_start_entered: got busy seen=%b, required 1", saw_busy); end
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL false_start_busy: got %b, required 0", busy); end
    n_checks++; if (data_valid !== 1'b0) begin n_fail++; $display("FAIL false_start_valid: got %b, required 0", data_valid); end
    n_checks++; if (sb_q.size() != 0) begin n_fail++; $display("FAIL false_start_queue: got %0d pending, required 0", sb_q.size()); end
  endtask

  task automatic test_clamp;
    sb_q.push_back('{9'h015, 1'b0, 1'b0});
    send_frame(9'h015, 5, 4'd2, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, -1);
    sb_q.push_back('{9'h1C3, 1'b0, 1'b0});
    send_frame(9'h1C3, 9, 4'd15, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, -1);
    for (int i = 0; i < 400 && sb_q.size() != 0; i++) @(posedge clk);
    n_checks++; if (sb_q.size() != 0) begin n_fail++; $display("FAIL drain_clamp: got %0d pending, required 0", sb_q.size()); end
  endtask

  task automatic test_back_to_back;
    sb_on = 1'b0;
    rdy = 1'b0;
    n_ovr = 0;
    send_frame(9'h012, 8, 4'd8, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, -1);
    send_frame(9'h034, 8, 4'd8, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, -1);
    repeat (4) @(posedge clk);
    #1;
    $display("HOLD word data=%h valid=%b overrun pulses=%0d", data, data_valid, n_ovr);
    n_checks++; if (data !== 9'h012) begin n_fail++; $display("FAIL hold_data: got %h, required 012", data); end
    n_checks++; if (data_valid !== 1'b1) begin n_fail++; $display("FAIL hold_valid: got %b, required 1", data_valid); end
    n_checks++; if (n_ovr != 1) begin n_fail++; $display("FAIL overrun_pulses: got %0d, required 1", n_ovr); end
    rdy = 1'b1;
    @(posedge clk);
    #1;
    rdy = 1'b0;
    n_checks++; if (data_valid !== 1'b0) begin n_fail++; $display("FAIL accept_clears_valid: got %b, required 0", data_valid); end
    n_ovr = 0;
    rdy = 1'b1;
    sb_on = 1'b1;
    sb_q.push_back('{9'h012, 1'b0, 1'b0});
    send_frame(9'h012, 8, 4'd8, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, -1);
    sb_q.push_back('{9'h034, 1'b0, 1'b0});
    send_frame(9'h034, 8, 4'd8, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, -1);
    for (int i = 0; i < 400 && sb_q.size() != 0; i++) @(posedge clk);
    n_checks++; if (sb_q.size() != 0) begin n_fail++; $display("FAIL drain_b2b: got %0d pending, required 0", sb_q.size()); end
    n_checks++; if (n_ovr != 0) begin n_fail++; $display("FAIL b2b_no_overrun: got %0d pulses, required 0", n_ovr); end
  endtask

  task automatic test_reset_mid;
    send_frame(9'h0A3, 8, 4'd8, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4);
    n_checks++; if (data !== 9'h000) begin n_fail++; $display("FAIL midrst_data: got %h, required 000", data); end
    n_checks++; if (data_valid !== 1'b0) begin n_fail++; $display("FAIL midrst_valid: got %b, required 0", data_valid); end
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL midrst_busy: got %b, required 0", busy); end
    n_checks++; if ({parity_err, framing_err, overrun} !== 3'b000) begin n_fail++; $display("FAIL midrst_flags: got %b, required 000", {parity_err, framing_err, overrun}); end
    rst = 1'b0;
    repeat (2 * OS) @(posedge clk);
    sb_q.push_back('{9'h0A3, 1'b0, 1'b0});
    send_frame(9'h0A3, 8, 4'd8, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, -1);
    for (int i = 0; i < 400 && sb_q.size() != 0; i++) @(posedge clk);
    n_checks++; if (sb_q.size() != 0) begin n_fail++; $display("FAIL drain_after_rst: got %0d pending, required 0", sb_q.size()); end
  endtask

  initial begin
    test_reset();
    test_8n1();
    test_parity();
    test_framing();
    test_false_start();
    test_clamp();
    test_back_to_back();
    test_reset_mid();
    repeat (4) @(posedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, required bench completion");
    $fatal(1, "watchdog expired");
  end

endmodule
